bsg_manycore_load_receiver: RTL
===============================

BSG_MANYCORE_LOAD_RECEIVER -- requirements
Module: bsg_manycore_load_receiver

Interface
REQ-001 Parameter addr_width_p, default 32: packet address width.
REQ-002 Parameter data_width_p, default 32: packet data width.
REQ-003 Parameter x_cord_width_p, default 2, and y_cord_width_p, default 3: mesh coordinate widths.
REQ-004 Parameter dmem_els_p, default 1024: local data-memory words; dmem_addr_width_lp = safe clog2(dmem_els_p).
REQ-005 clk_i  in  1  single clock; reset_i  in  1  synchronous, active-high reset.
REQ-006 my_x_i  in  x_cord_width_p  own x coordinate; my_y_i  in  y_cord_width_p  own y coordinate.
REQ-007 in_v_i  in  1  valid; in_packet_i  in  packet width  manycore request packet; in_ready_o  out  1  ready.
REQ-008 mem_v_o  out  1  request valid; mem_w_o  out  1  write; mem_addr_o  out  dmem_addr_width_lp  word address; mem_data_o  out  data_width_p  write data; mem_mask_o  out  data_width_p/8  byte mask; mem_yumi_i  in  1  memory accepts the request.
REQ-009 mem_data_i  in  data_width_p  read data, valid exactly one cycle after the accepting mem_yumi_i.
REQ-010 ret_v_o  out  1  valid; ret_packet_o  out  return-packet width  credit/data return; ret_ready_i  in  1  ready.
REQ-011 freeze_o  out  1  tile freeze; err_o  out  1  sticky bad-opcode flag.

Function
REQ-012 in_v_i/in_ready_o and ret_v_o/ret_ready_i are valid/ready handshakes; a transfer occurs on a cycle where both are high; ret_v_o and ret_packet_o are held stable until the transfer.
REQ-013 Input is buffered by a 2-entry FIFO; in_ready_o is high whenever the FIFO is not full, independent of in_v_i.
REQ-014 FSM states: IDLE, MEM_REQ, READ_WAIT, RETURN; exactly one request is in service at a time.
REQ-015 IDLE with FIFO non-empty: dequeue, decode, and go to MEM_REQ for a dmem access, or go to RETURN for CSR and bad-opcode requests.
REQ-016 Decode: op 0 = load, 1 = store, 2 and 3 = bad. addr[addr_width_p-1]=1 selects CSR space; otherwise mem_addr_o = addr[dmem_addr_width_lp-1:0] and upper bits are ignored.
REQ-017 MEM_REQ: mem_v_o=1, mem_w_o=(op==store), mem_mask_o=op_ex mask for stores, all-ones for loads. Stays in MEM_REQ until mem_yumi_i; then a store goes to RETURN and a load goes to READ_WAIT.
REQ-018 READ_WAIT: capture mem_data_i into the return data register, then go to RETURN.
REQ-019 RETURN: ret_v_o=1; return destination = request src x/y; type = data for a load, credit otherwise; data = captured read data for a load, 0 otherwise. On transfer, go to IDLE.
REQ-020 CSR store, offset addr[1:0]=0: freeze_o <= data[0], applied on the cycle the FSM leaves IDLE.
REQ-021 CSR load, offset 0: returns {0, freeze_o}; any other CSR offset: store ignored, load returns 0; always returns exactly one packet.
REQ-022 Bad opcode: err_o set to 1 and held until reset; no memory access; credit return.
REQ-023 Minimum latency: store (dequeue to ret_v_o) = 2 cycles with mem_yumi_i held high; load = 3 cycles.
REQ-024 An enqueue and a dequeue in the same cycle on a full FIFO are not allowed (in_ready_o=0); an enqueue and a dequeue on a 1-entry FIFO are both accepted.
REQ-025 Every accepted request produces exactly one return packet, in arrival order.

Reset
REQ-026 While reset_i is high: FIFO empty, FSM=IDLE, freeze_o=1, err_o=0, mem_v_o=0, ret_v_o=0, in_ready_o=0.
REQ-027 Reset asserted mid-operation discards the in-flight request and buffered requests without issuing a return; the first cycle after reset deassertion has in_ready_o=1.

Structure
REQ-028 The return-packet struct (type enum {credit, data}, data, y, x), the op encodings, and the CSR offsets live in the shared manycore package/header next to the packet macros.
REQ-029 The input buffer is the existing bsg_two_fifo; the FSM and decode are inline.

Verification
REQ-030 Store addr=0x10, data=0xDEADBEEF, mask=0xF, src=(3,4), mem_yumi_i=1 -> one write to word 0x10, then a credit return to (3,4) 2 cycles after dequeue.
REQ-031 Load addr=0x10 after REQ-030, memory model returns 0xDEADBEEF -> data return 0xDEADBEEF to src 3 cycles after dequeue.
REQ-032 CSR store offset 0, data=0 -> freeze_o 1->0 and credit return; a following CSR load offset 0 -> data=0.
REQ-033 Op=3 request -> err_o=1 stays high, no mem_v_o, credit return issued.
REQ-034 Three back-to-back stores with ret_ready_i=0 for 20 cycles -> in_ready_o drops after 2 buffered, then 3 ordered credits are returned once ready rises.
REQ-035 reset_i pulsed while in MEM_REQ with 2 queued requests -> no return issued, freeze_o=1, and the next request is processed normally.

Source files
------------

// File: rtl/bsg_manycore_load_receiver_pkg.sv
// Shared encodings for the manycore load receiver: request opcodes, return
// packet type, FSM states and CSR offsets.
package bsg_manycore_load_receiver_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_BAD2  = 2'd2,
    OP_BAD3  = 2'd3
  } op_e;

  typedef enum logic {
    RET_CREDIT = 1'b0,
    RET_DATA   = 1'b1
  } ret_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_REQ,
    S_READ_WAIT,
    S_RETURN
  } state_e;

  localparam logic [1:0] CSR_FREEZE_OFFSET = 2'd0;

  // clog2 that never yields a zero-width address
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_manycore_load_receiver_if.sv
// Local data-memory port of the load receiver; master is the receiver side.
interface bsg_manycore_load_receiver_if #(
  parameter int data_width_p      = 32,
  parameter int dmem_addr_width_p = 10
);
  logic                         mem_v_o;
  logic                         mem_w_o;
  logic [dmem_addr_width_p-1:0] mem_addr_o;
  logic [data_width_p-1:0]      mem_data_o;
  logic [data_width_p/8-1:0]    mem_mask_o;
  logic                         mem_yumi_i;
  logic [data_width_p-1:0]      mem_data_i;

  modport master (
    output mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o,
    input  mem_yumi_i, mem_data_i
  );

  modport slave (
    input  mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o,
    output mem_yumi_i, mem_data_i
  );
endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry valid/ready FIFO with a yumi-style dequeue.
module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_q [0:1];
  logic               wptr_q, rptr_q;
  logic [1:0]         count_q, count_d;
  logic               enq, deq;

  // Ready is suppressed during reset so nothing is accepted into a clearing buffer
  assign ready_o = (count_q != 2'd2) & ~reset_i;
  assign v_o     = (count_q != 2'd0);
  assign data_o  = mem_q[rptr_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign count_d = count_q + {1'b0, enq} - {1'b0, deq};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (enq) wptr_q <= ~wptr_q;
      if (deq) rptr_q <= ~rptr_q;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_load_receiver.sv
// Services manycore load/store/CSR requests against local dmem and returns
// exactly one credit or data packet per request, in arrival order.
module bsg_manycore_load_receiver
  import bsg_manycore_load_receiver_pkg::*;
#(
  parameter int addr_width_p   = 32,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 2,
  parameter int y_cord_width_p = 3,
  parameter int dmem_els_p     = 1024
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,

  input  logic in_v_i,
  input  logic [addr_width_p+2+data_width_p/8+data_width_p+y_cord_width_p+x_cord_width_p-1:0] in_packet_i,
  output logic in_ready_o,

  bsg_manycore_load_receiver_if.master mem_if,

  output logic ret_v_o,
  output logic [1+data_width_p+y_cord_width_p+x_cord_width_p-1:0] ret_packet_o,
  input  logic ret_ready_i,

  output logic freeze_o,
  output logic err_o
);

  localparam int dmem_addr_width_lp = safe_clog2(dmem_els_p);

  typedef struct packed {
    logic [addr_width_p-1:0]   addr;
    op_e                       op;
    logic [data_width_p/8-1:0] op_ex;
    logic [data_width_p-1:0]   payload;
    logic [y_cord_width_p-1:0] src_y;
    logic [x_cord_width_p-1:0] src_x;
  } req_pkt_s;

  typedef struct packed {
    ret_type_e                 pkt_type;
    logic [data_width_p-1:0]   data;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } ret_pkt_s;

  logic     fifo_v, fifo_yumi;
  req_pkt_s fifo_data;

  bsg_two_fifo #(.width_p($bits(req_pkt_s))) input_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ready_o (in_ready_o),
    .v_i     (in_v_i),
    .data_i  (in_packet_i),
    .v_o     (fifo_v),
    .data_o  (fifo_data),
    .yumi_i  (fifo_yumi)
  );

  state_e                  state_q, state_d;
  req_pkt_s                req_q, req_d;
  ret_type_e               ret_type_q, ret_type_d;
  logic [data_width_p-1:0] ret_data_q, ret_data_d;
  logic                    freeze_q, freeze_d;
  logic                    err_q, err_d;

  logic deq_bad, deq_csr, deq_off_zero;
  assign deq_bad      = fifo_data.op[1];
  assign deq_csr      = fifo_data.addr[addr_width_p-1];
  assign deq_off_zero = (fifo_data.addr[1:0] == CSR_FREEZE_OFFSET);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    ret_type_d = ret_type_q;
    ret_data_d = ret_data_q;
    freeze_d   = freeze_q;
    err_d      = err_q;
    fifo_yumi  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (fifo_v) begin
          fifo_yumi  = 1'b1;
          req_d      = fifo_data;
          ret_type_d = (fifo_data.op == OP_LOAD) ? RET_DATA : RET_CREDIT;
          ret_data_d = '0;
          if (deq_bad) begin
            err_d   = 1'b1;
            state_d = S_RETURN;
          end else if (deq_csr) begin
            // CSR reads see freeze before any update from this same request
            if (deq_off_zero && fifo_data.op == OP_STORE)
              freeze_d = fifo_data.payload[0];
            if (deq_off_zero && fifo_data.op == OP_LOAD)
              ret_data_d = {{(data_width_p-1){1'b0}}, freeze_q};
            state_d = S_RETURN;
          end else begin
            state_d = S_MEM_REQ;
          end
        end
      end
      S_MEM_REQ: begin
        if (mem_if.mem_yumi_i)
          state_d = (req_q.op == OP_STORE) ? S_RETURN : S_READ_WAIT;
      end
      S_READ_WAIT: begin
        ret_data_d = mem_if.mem_data_i;
        state_d    = S_RETURN;
      end
      S_RETURN: begin
        if (ret_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      ret_type_q <= RET_CREDIT;
      ret_data_q <= '0;
      freeze_q   <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      ret_type_q <= ret_type_d;
      ret_data_q <= ret_data_d;
      freeze_q   <= freeze_d;
      err_q      <= err_d;
    end
  end

  ret_pkt_s ret_pkt;
  assign ret_pkt.pkt_type = ret_type_q;
  assign ret_pkt.data     = ret_data_q;
  assign ret_pkt.y_cord   = req_q.src_y;
  assign ret_pkt.x_cord   = req_q.src_x;

  // Handshake valids are forced low for the whole reset pulse, not just after the edge
  assign mem_if.mem_v_o    = (state_q == S_MEM_REQ) & ~reset_i;
  assign mem_if.mem_w_o    = (req_q.op == OP_STORE);
  assign mem_if.mem_addr_o = req_q.addr[dmem_addr_width_lp-1:0];
  assign mem_if.mem_data_o = req_q.payload;
  assign mem_if.mem_mask_o = (req_q.op == OP_STORE) ? req_q.op_ex : '1;

  assign ret_v_o      = (state_q == S_RETURN) & ~reset_i;
  assign ret_packet_o = ret_pkt;
  assign freeze_o     = freeze_q;
  assign err_o        = err_q;

  logic unused_bits;
  assign unused_bits = ^{my_x_i, my_y_i, req_q.addr};

endmodule
